clock_ratio_meter: RTL and testbench



---
 rtl/clock_ratio_meter_pkg.sv | 27 ++
 rtl/clock_ratio_meter_edge_sync_detect.sv | 67 ++++++
 rtl/clock_ratio_meter.sv | 165 ++++++++++++++++
 tb/tb_clock_ratio_meter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/clock_ratio_meter_pkg.sv
// Shared types and constants for the clock ratio meter and its edge detector.
// Build option CLK_RATIO_GLITCH_FILTER_EN is consumed by edge_sync_detect.
package clock_ratio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int MATCH_W    = 4;
    localparam int SYNC_DEPTH = 2;

    localparam logic [MATCH_W-1:0] MATCH_MAX = 4'hF;

    // Saturating increment so a long run of identical periods never wraps to 0.
    function automatic logic [MATCH_W-1:0] match_inc(input logic [MATCH_W-1:0] m);
        logic [MATCH_W-1:0] r;
        if (m == MATCH_MAX) begin
            r = m;
        end else begin
            r = m + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/clock_ratio_meter_edge_sync_detect.sv
// Synchronizes an asynchronous level into clk and reports rise/fall/level.
// With CLK_RATIO_GLITCH_FILTER_EN defined, single-cycle pulses are rejected.
module edge_sync_detect
    import clock_ratio_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise,
    output logic fall,
    output logic level
);

    logic [SYNC_DEPTH-1:0] sync_r;
    logic                  prev_r;
    logic                  cur_s;

    // Metastability synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_DEPTH{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_DEPTH-2:0], async_in};
        end
    end

`ifdef CLK_RATIO_GLITCH_FILTER_EN
    logic stage_r;

    // Extra sample so two consecutive synchronized values can be compared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_r <= 1'b0;
        end else begin
            stage_r <= sync_r[SYNC_DEPTH-1];
        end
    end

    // Accept a new level only once two samples agree; otherwise hold the old one.
    always_comb begin
        if (sync_r[SYNC_DEPTH-1] == stage_r) begin
            cur_s = stage_r;
        end else begin
            cur_s = prev_r;
        end
    end
`else
    // Unfiltered: the last synchronizer flop is the current level.
    always_comb begin
        cur_s = sync_r[SYNC_DEPTH-1];
    end
`endif

    // Previous accepted level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= cur_s;
        end
    end

    assign rise  = cur_s & ~prev_r;
    assign fall  = ~cur_s & prev_r;
    assign level = cur_s;

endmodule

// File: rtl/clock_ratio_meter.sv
// Measures period/high time of a slow clock in clk cycles, reports lock and timeout.
// Optional glitch filter in the input path: CLK_RATIO_GLITCH_FILTER_EN.
module clock_ratio_meter
    import clock_ratio_pkg::*;
#(
    parameter int CWIDTH      = 20,
    parameter int LOCK_COUNT  = 4,
    parameter int TIMEOUT_CYC = 1048575
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_in,
    output logic [CWIDTH-1:0] period,
    output logic [CWIDTH-1:0] high_time,
    output logic              meas_valid,
    output logic              locked,
    output logic              timeout
);

    localparam logic [CWIDTH-1:0]  CNT_ONE  = {{(CWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CWIDTH-1:0]  CNT_MAX  = CWIDTH'(TIMEOUT_CYC);
    localparam logic [MATCH_W-1:0] LOCK_THR = MATCH_W'(LOCK_COUNT - 1);

    logic rise_s;
    logic fall_s;
    logic level_s;

    edge_sync_detect u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (clk_in),
        .rise     (rise_s),
        .fall     (fall_s),
        .level    (level_s)
    );

    state_t             state_r,      state_nx;
    logic [CWIDTH-1:0]  cnt_r,        cnt_nx;
    logic [CWIDTH-1:0]  hcap_r,       hcap_nx;
    logic [CWIDTH-1:0]  period_r,     period_nx;
    logic [CWIDTH-1:0]  high_time_r,  high_time_nx;
    logic               meas_valid_r, meas_valid_nx;
    logic               locked_r,     locked_nx;
    logic               timeout_r,    timeout_nx;
    logic [MATCH_W-1:0] match_r,      match_nx;

    logic               meas_s;
    logic               expire_s;
    logic [CWIDTH-1:0]  meas_high_s;

    // Next-state and measurement datapath.
    always_comb begin
        state_nx      = state_r;
        cnt_nx        = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
        hcap_nx       = hcap_r;
        period_nx     = period_r;
        high_time_nx  = high_time_r;
        meas_valid_nx = 1'b0;
        locked_nx     = locked_r;
        timeout_nx    = timeout_r;
        match_nx      = match_r;
        meas_s        = 1'b0;
        expire_s      = 1'b0;
        meas_high_s   = hcap_r;

        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    state_nx   = HIGH;
                    cnt_nx     = CNT_ONE;
                    timeout_nx = 1'b0;
                end else begin
                    state_nx   = IDLE;
                end
            end
            HIGH: begin
                // A rise while still high means the fall was missed: short period.
                if (rise_s) begin
                    meas_s      = 1'b1;
                    hcap_nx     = cnt_r;
                    meas_high_s = cnt_r;
                end else if (cnt_r == CNT_MAX) begin
                    expire_s = 1'b1;
                end else if (fall_s && !level_s) begin
                    hcap_nx  = cnt_r;
                    state_nx = LOW;
                end else begin
                    state_nx = HIGH;
                end
            end
            LOW: begin
                if (rise_s) begin
                    meas_s = 1'b1;
                end else if (cnt_r == CNT_MAX) begin
                    expire_s = 1'b1;
                end else begin
                    state_nx = LOW;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Rise takes priority over timeout because expire_s is only set without a rise.
        if (meas_s) begin
            period_nx     = cnt_r;
            high_time_nx  = meas_high_s;
            meas_valid_nx = 1'b1;
            cnt_nx        = CNT_ONE;
            state_nx      = HIGH;
            timeout_nx    = 1'b0;
            if (cnt_r == period_r) begin
                match_nx = match_inc(match_r);
                if (match_r >= LOCK_THR) begin
                    locked_nx = 1'b1;
                end else begin
                    locked_nx = locked_r;
                end
            end else begin
                match_nx  = {MATCH_W{1'b0}};
                locked_nx = 1'b0;
            end
        end else if (expire_s) begin
            timeout_nx = 1'b1;
            locked_nx  = 1'b0;
            match_nx   = {MATCH_W{1'b0}};
            state_nx   = IDLE;
        end else begin
            meas_valid_nx = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= {CWIDTH{1'b0}};
            hcap_r       <= {CWIDTH{1'b0}};
            period_r     <= {CWIDTH{1'b0}};
            high_time_r  <= {CWIDTH{1'b0}};
            meas_valid_r <= 1'b0;
            locked_r     <= 1'b0;
            timeout_r    <= 1'b0;
            match_r      <= {MATCH_W{1'b0}};
        end else begin
            state_r      <= state_nx;
            cnt_r        <= cnt_nx;
            hcap_r       <= hcap_nx;
            period_r     <= period_nx;
            high_time_r  <= high_time_nx;
            meas_valid_r <= meas_valid_nx;
            locked_r     <= locked_nx;
            timeout_r    <= timeout_nx;
            match_r      <= match_nx;
        end
    end

    assign period     = period_r;
    assign high_time  = high_time_r;
    assign meas_valid = meas_valid_r;
    assign locked     = locked_r;
    assign timeout    = timeout_r;

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Self-checking bench for clock_ratio_meter: directed waveforms plus random periods
// checked every cycle against an edge-timestamp reference model.
module tb_clock_ratio_meter;

    localparam int CW = 20;
    localparam int LC = 4;
    localparam int TO = 100;
    localparam int DET_LAT = 2;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          clk_in = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          locked;
    logic          timeout;

    int errors = 0;
    int checks = 0;

    clock_ratio_meter #(
        .CWIDTH      (CW),
        .LOCK_COUNT  (LC),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_in     (clk_in),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    // Reference model: edges timestamped by clk edge index, seen DET_LAT edges late.
    int   e_idx;
    logic vprev;
    logic [1:0] pipe [DET_LAT];
    bit   active;
    int   rise_t;
    int   fall_t;
    bit   has_fall;
    int   m_period, m_high, m_mv, m_lock, m_to;
    int   per_q [$];
    int   barrier;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        e_idx = 0; vprev = 1'b0;
        for (int i = 0; i < DET_LAT; i++) pipe[i] = 2'b00;
        active = 1'b0; rise_t = 0; fall_t = 0; has_fall = 1'b0;
        m_period = 0; m_high = 0; m_mv = 0; m_lock = 0; m_to = 0;
        per_q.delete(); per_q.push_back(0); barrier = 0;
    endtask

    task automatic record_period(input int p);
        int run;
        per_q.push_back(p);
        run = 0;
        for (int i = per_q.size() - 1; i > barrier; i--) begin
            if (per_q[i] == per_q[i-1]) run++;
            else break;
        end
        m_lock = (run >= LC) ? 1 : 0;
    endtask

    task automatic model_step(input logic v);
        logic [1:0] ev;
        e_idx++;
        ev = pipe[DET_LAT-1];
        for (int i = DET_LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0] = {v & ~vprev, ~v & vprev};
        vprev = v;
        m_mv = 0;
        if (!active) begin
            if (ev[1]) begin
                active = 1'b1; rise_t = e_idx; has_fall = 1'b0; m_to = 0;
            end
        end else if (ev[1]) begin
            m_period = e_idx - rise_t;
            m_high   = has_fall ? (fall_t - rise_t) : m_period;
            m_mv     = 1;
            m_to     = 0;
            record_period(m_period);
            rise_t = e_idx; has_fall = 1'b0;
        end else if (e_idx - rise_t == TO) begin
            m_to = 1; m_lock = 0; active = 1'b0;
            barrier = per_q.size() - 1;
        end else if (ev[0] && !has_fall) begin
            fall_t = e_idx; has_fall = 1'b1;
        end
    endtask

    task automatic tick(input logic v);
        @(negedge clk);
        clk_in = v;
        @(posedge clk);
        model_step(v);
        #1;
        chk("period",     32'(period),    32'(m_period));
        chk("high_time",  32'(high_time), 32'(m_high));
        chk("meas_valid", 32'(meas_valid), 32'(m_mv));
        chk("locked",     32'(locked),    32'(m_lock));
        chk("timeout",    32'(timeout),   32'(m_to));
    endtask

    task automatic run_wave(input int hi, input int lo, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi; i++) tick(1'b1);
            for (int i = 0; i < lo; i++) tick(1'b0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_period"},    32'(period),     32'd0);
        chk({tag, "_high_time"}, 32'(high_time),  32'd0);
        chk({tag, "_meas_valid"},32'(meas_valid), 32'd0);
        chk({tag, "_locked"},    32'(locked),     32'd0);
        chk({tag, "_timeout"},   32'(timeout),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=time_limit expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi, lo, reps;
        model_reset();
        #2 rst_n = 1'b0;
        #2 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Divide-by-4: locks on the fifth measurement.
        run_wave(2, 2, 8);
        chk("div4_period", 32'(period), 32'd4);
        chk("div4_high",   32'(high_time), 32'd2);
        chk("div4_locked", 32'(locked), 32'd1);

        // Odd divider 3/4.
        run_wave(3, 4, 8);
        chk("div7_period", 32'(period), 32'd7);
        chk("div7_high",   32'(high_time), 32'd3);
        chk("div7_locked", 32'(locked), 32'd1);

        // Switch to div-6: the first div-6 measurement drops lock.
        run_wave(3, 3, 1);
        tick(1'b1); tick(1'b1); tick(1'b1);
        chk("div6_first_mv",     32'(meas_valid), 32'd1);
        chk("div6_first_period", 32'(period), 32'd6);
        chk("div6_first_locked", 32'(locked), 32'd0);
        repeat (3) tick(1'b0);
        run_wave(3, 3, 6);
        chk("div6_relock", 32'(locked), 32'd1);

        // Lock on div-4, then stop the clock.
        run_wave(2, 2, 8);
        run_wave(0, 110, 1);
        chk("to_flag",   32'(timeout), 32'd1);
        chk("to_locked", 32'(locked), 32'd0);
        chk("to_period", 32'(period), 32'd4);
        run_wave(2, 2, 1);
        chk("to_cleared", 32'(timeout), 32'd0);
        run_wave(2, 2, 3);

        // Randomized periods, occasionally long enough to time out.
        for (int k = 0; k < 40; k++) begin
            hi   = $urandom_range(1, 10);
            lo   = ($urandom_range(0, 7) == 0) ? $urandom_range(90, 115) : $urandom_range(1, 10);
            reps = $urandom_range(1, 6);
            run_wave(hi, lo, reps);
        end

        // Single-cycle pulses after a timeout.
        run_wave(0, 110, 1);
        run_wave(1, 20, 1);
        tick(1'b1); tick(1'b0); tick(1'b0);
        chk("pulse_mv",     32'(meas_valid), 32'd1);
        chk("pulse_high",   32'(high_time), 32'd1);
        chk("pulse_period", 32'(period), 32'd21);
        repeat (5) tick(1'b0);

        // Asynchronous reset while HIGH.
        tick(1'b1); tick(1'b1); tick(1'b1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        @(negedge clk);
        clk_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_wave(2, 2, 3);
        chk("post_rst_period", 32'(period), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
